// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, reset PC default and queue entry type for the fetch stage
package fetch_unit_pkg;
  localparam int WORD = 16;
  localparam logic [WORD-1:0] FETCH_RESET_PC = 16'h0000;
  localparam int FETCH_MAX_DEPTH = 8;
  localparam int FETCH_CNT_W = $clog2(FETCH_MAX_DEPTH) + 1;
  typedef logic [WORD-1:0] word_t;
  typedef struct packed {
    word_t ir;
    word_t pc;
  } entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry prefetch FIFO of {ir, pc}; clear beats push, head holds last pop when empty
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  entry_t                 din,
  output entry_t                 head,
  output logic [FETCH_CNT_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  entry_t last;
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (push && !clear) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      if (pop) last <= mem[rd_ptr];
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + FETCH_CNT_W'(push) - FETCH_CNT_W'(pop);
      end
    end
  // once drained, keep presenting the entry that was handed over last
  always_comb head = (count != '0) ? mem[rd_ptr] : last;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, credit-limited instruction reads, squash on redirect, valid/ready hand-off
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [WORD-1:0]  RESET_PC = FETCH_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            halt,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  output logic            mem_rd,
  output logic [WORD-1:0] mem_addr,
  input  logic [WORD-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_ir,
  output logic [WORD-1:0] out_pc
);
  localparam int UW = FETCH_CNT_W + 1;
  word_t pc, ret_tag;
  logic ret_v, issue, push, pop;
  logic [FETCH_CNT_W-1:0] count;
  logic [UW-1:0] used;
  entry_t head;
  // reads on the bus and awaiting data both hold a queue slot in reserve
  always_comb begin
    used      = UW'(count) + UW'(mem_rd) + UW'(ret_v);
    issue     = !halt && !redirect && (used < UW'(DEPTH));
    out_valid = count != '0;
    pop       = out_valid && out_ready;
    push      = ret_v && !redirect;
    out_ir    = head.ir;
    out_pc    = head.pc;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc       <= RESET_PC;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      ret_v    <= 1'b0;
      ret_tag  <= '0;
    end else begin
      mem_rd  <= issue;
      ret_v   <= mem_rd && !redirect;
      ret_tag <= mem_addr;
      if (issue) mem_addr <= pc;
      pc <= redirect ? redirect_pc : issue ? pc + 16'd1 : pc;
    end
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .din   ({mem_rdata, ret_tag}),
    .head  (head),
    .count (count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench with a generation-tagged expected-PC scoreboard and negedge monitor
module tb_fetch_unit;
  logic clk = 1'b0, reset = 1'b1, halt = 1'b0, redirect = 1'b0, out_ready = 1'b0;
  logic [15:0] redirect_pc = '0, mem_rdata = '0;
  logic mem_rd, out_valid;
  logic [15:0] mem_addr, out_ir, out_pc;
  typedef struct {
    int          gen;
    logic [15:0] pc;
  } exp_t;
  exp_t exp_q[$];
  int issue_gen = 0, cur_gen = 0, checks = 0, errors = 0, xfers = 0;
  logic in_reset = 1'b0, prev_hold = 1'b0;
  logic [15:0] prev_ir = '0, prev_pc = '0;

  fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ir      (out_ir),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  // memory: data valid exactly one cycle after the read strobe is sampled, garbage otherwise
  always @(posedge clk) mem_rdata <= mem_rd ? mem_word(mem_addr) : 16'($urandom);

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // a new fetch stream: sequential 16-bit wrapping PCs from start, tagged with a fresh generation
  task automatic new_stream(input logic [15:0] start);
    issue_gen++;
    for (int i = 0; i < 256; i++) exp_q.push_back('{issue_gen, 16'(start + i)});
  endtask

  task automatic prune();
    while (exp_q.size() > 0 && exp_q[0].gen < cur_gen) void'(exp_q.pop_front());
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (!in_reset) cur_gen++;
      in_reset  = 1'b1;
      prev_hold = 1'b0;
    end else begin
      in_reset = 1'b0;
      if (prev_hold) begin
        check("hold_valid", 16'(out_valid), 16'd1);
        check("hold_ir", out_ir, prev_ir);
        check("hold_pc", out_pc, prev_pc);
      end
      if (out_valid && out_ready) begin
        prune();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty actual_pc=%h t=%0t", out_pc, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_ir", out_ir, mem_word(e.pc));
        end
        xfers++;
      end
      prev_hold = out_valid && !out_ready && !redirect;
      prev_ir   = out_ir;
      prev_pc   = out_pc;
      if (redirect) cur_gen++;
    end
  end

  initial begin
    int n, x0;
    logic [15:0] nxt;
    new_stream(16'h0000);
    #1 reset = 1'b0;
    repeat (2) cyc();
    check("rst_mem_rd", 16'(mem_rd), 16'd0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_ir", out_ir, 16'h0000);
    check("rst_out_pc", out_pc, 16'h0000);
    reset = 1'b1;
    out_ready = 1'b1;
    cyc();
    check("first_rd", 16'(mem_rd), 16'd1);
    check("first_addr", mem_addr, 16'h0000);
    repeat (4) cyc();
    x0 = xfers;
    repeat (20) cyc();
    check("no_gaps", 16'(xfers - x0), 16'd20);
    // reset mid-run with reads in flight, then a stalled consumer fills the queue
    new_stream(16'h0000);
    reset = 1'b0;
    out_ready = 1'b0;
    #1;
    check("midrst_mem_rd", 16'(mem_rd), 16'd0);
    check("midrst_valid", 16'(out_valid), 16'd0);
    check("midrst_pc", out_pc, 16'h0000);
    cyc();
    reset = 1'b1;
    cyc();
    check("rel_rd", 16'(mem_rd), 16'd1);
    check("rel_addr", mem_addr, 16'h0000);
    n = 1;
    repeat (10) begin
      cyc();
      n += int'(mem_rd);
    end
    check("full_reads", 16'(n), 16'd4);
    check("full_no_rd", 16'(mem_rd), 16'd0);
    check("full_valid", 16'(out_valid), 16'd1);
    check("full_head_pc", out_pc, 16'h0000);
    check("full_head_ir", out_ir, 16'h1000);
    out_ready = 1'b1;
    repeat (8) cyc();
    // redirect with reads in flight: squashed, first new word three cycles later
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    new_stream(16'h0040);
    cyc();
    redirect = 1'b0;
    check("redir_lat0", 16'(out_valid), 16'd0);
    cyc();
    check("redir_lat1", 16'(out_valid), 16'd0);
    check("redir_addr", mem_addr, 16'h0040);
    cyc();
    check("redir_lat2", 16'(out_valid), 16'd0);
    cyc();
    check("redir_lat3", 16'(out_valid), 16'd1);
    check("redir_pc", out_pc, 16'h0040);
    repeat (6) cyc();
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    new_stream(16'hFFFE);
    cyc();
    redirect = 1'b0;
    repeat (8) cyc();
    // halt: everything already requested drains, nothing new issues
    halt = 1'b1;
    x0 = xfers;
    n = 0;
    repeat (6) begin
      cyc();
      n += int'(mem_rd);
    end
    check("halt_no_issue", 16'(n), 16'd0);
    check("halt_drain", 16'(xfers - x0), 16'd3);
    prune();
    nxt = exp_q[0].pc;
    halt = 1'b0;
    cyc();
    check("resume_rd", 16'(mem_rd), 16'd1);
    check("resume_addr", mem_addr, nxt);
    repeat (6) cyc();
    repeat (1500) begin
      out_ready = ($urandom % 4) != 0;
      halt = ($urandom % 8) == 0;
      redirect = ($urandom % 16) == 0;
      if (redirect) begin
        redirect_pc = ($urandom % 4 == 0) ? 16'hFFFE : 16'($urandom);
        new_stream(redirect_pc);
      end
      cyc();
    end
    halt = 1'b0;
    redirect = 1'b0;
    out_ready = 1'b1;
    repeat (10) cyc();
    check("progress", 16'(xfers >= 300), 16'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
